// File: rtl/uart_frame_rx.sv
// Packet deframer for the UART RX byte stream.
// Hunts for SOF, LEN, payload[LEN], CHK frames, buffers the payload and
// forwards it on a valid/ready output only when the checksum is good.
// Status pulses and a saturating error count report every frame outcome.
module uart_frame_rx #(
    parameter int unsigned            DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0]  SOF_BYTE       = 8'hA5,
    parameter int unsigned            MAX_PAYLOAD    = 16,
    parameter int unsigned            TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  pkt_ok,
    output logic                  err_chk,
    output logic                  err_len,
    output logic                  err_timeout,
    output logic [7:0]            err_count
);

    localparam int unsigned AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam int unsigned LW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_SEND
    } state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         len_q, len_d;
    logic [AW-1:0]         wr_idx_q, wr_idx_d;
    logic [AW-1:0]         rd_idx_q, rd_idx_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [DATA_WIDTH-1:0] buf_q [MAX_PAYLOAD];
    logic [DATA_WIDTH-1:0] buf_d [MAX_PAYLOAD];
    logic                  pkt_ok_q, pkt_ok_d;
    logic                  err_chk_q, err_chk_d;
    logic                  err_len_q, err_len_d;
    logic                  err_timeout_q, err_timeout_d;
    logic [7:0]            err_count_q, err_count_d;

    logic                  in_fire;
    logic                  last_beat;
    logic                  tmo_expire;
    logic [DATA_WIDTH-1:0] chk_total;

    // Output views derived directly from registered state.
    always_comb begin
        in_ready    = (state_q != S_SEND);
        in_fire     = in_valid && in_ready;
        out_valid   = (state_q == S_SEND);
        out_data    = buf_q[rd_idx_q];
        last_beat   = ({1'b0, rd_idx_q} == (len_q - LW'(1)));
        out_last    = out_valid && last_beat;
        pkt_ok      = pkt_ok_q;
        err_chk     = err_chk_q;
        err_len     = err_len_q;
        err_timeout = err_timeout_q;
        err_count   = err_count_q;
    end

    // Next-state logic for the frame hunter, buffer and status pulses.
    // The counter is cleared on the consuming edge, so expiry is flagged one
    // count early to land the pulse TIMEOUT_CYCLES-1 cycles after that byte.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        sum_d         = sum_q;
        tmo_d         = tmo_q;
        buf_d         = buf_q;
        pkt_ok_d      = 1'b0;
        err_chk_d     = 1'b0;
        err_len_d     = 1'b0;
        err_timeout_d = 1'b0;
        chk_total     = sum_q + in_data;
        tmo_expire    = (tmo_q == TW'(TIMEOUT_CYCLES - 2));

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (in_fire && (in_data == SOF_BYTE)) begin
                    sum_d   = '0;
                    state_d = S_LEN;
                end
            end
            S_LEN, S_PAYLOAD, S_CHK: begin
                if (in_fire) begin
                    tmo_d = '0;
                    case (state_q)
                        S_LEN: begin
                            if ((in_data == '0) || (in_data > DATA_WIDTH'(MAX_PAYLOAD))) begin
                                err_len_d = 1'b1;
                                state_d   = S_IDLE;
                            end else begin
                                len_d    = LW'(in_data);
                                sum_d    = in_data;
                                wr_idx_d = '0;
                                state_d  = S_PAYLOAD;
                            end
                        end
                        S_PAYLOAD: begin
                            buf_d[wr_idx_q] = in_data;
                            sum_d           = sum_q + in_data;
                            wr_idx_d        = wr_idx_q + AW'(1);
                            if ({1'b0, wr_idx_q} == (len_q - LW'(1))) begin
                                state_d = S_CHK;
                            end
                        end
                        default: begin
                            if (chk_total == '0) begin
                                pkt_ok_d = 1'b1;
                                rd_idx_d = '0;
                                state_d  = S_SEND;
                            end else begin
                                err_chk_d = 1'b1;
                                state_d   = S_IDLE;
                            end
                        end
                    endcase
                end else if (tmo_expire) begin
                    err_timeout_d = 1'b1;
                    tmo_d         = '0;
                    state_d       = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_SEND: begin
                tmo_d = '0;
                if (out_ready) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        err_count_d = err_count_q;
        if ((pkt_ok_d == 1'b0) && (err_chk_d || err_len_d || err_timeout_d)
            && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Control and status registers, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            len_q         <= '0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            sum_q         <= '0;
            tmo_q         <= '0;
            pkt_ok_q      <= 1'b0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            sum_q         <= sum_d;
            tmo_q         <= tmo_d;
            pkt_ok_q      <= pkt_ok_d;
            err_chk_q     <= err_chk_d;
            err_len_q     <= err_len_d;
            err_timeout_q <= err_timeout_d;
            err_count_q   <= err_count_d;
        end
    end

    // Payload storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: a frame-level reference model
// predicts every output each cycle, plus literal expectations per scenario.
module tb_uart_frame_rx;

    localparam int unsigned MAXP = 16;
    localparam int unsigned TMO  = 50;
    localparam logic [7:0]  SOF  = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;
    logic       pkt_ok, err_chk, err_len, err_timeout;
    logic [7:0] err_count;

    uart_frame_rx #(
        .DATA_WIDTH    (8),
        .SOF_BYTE      (SOF),
        .MAX_PAYLOAD   (MAXP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .pkt_ok     (pkt_ok),
        .err_chk    (err_chk),
        .err_len    (err_len),
        .err_timeout(err_timeout),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endfunction

    // ---------------- reference model (frame level) ----------------
    logic [7:0] frame[$];
    logic [7:0] outq[$];
    bit         in_frame = 0;
    int         idle = 0;
    bit         m_pkt = 0, m_chk = 0, m_len = 0, m_tmo = 0;
    int         m_cnt = 0;
    int         fsum;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            frame.delete();
            outq.delete();
            in_frame = 0;
            idle = 0;
            m_pkt = 0; m_chk = 0; m_len = 0; m_tmo = 0;
            m_cnt = 0;
        end else begin
            m_pkt = 0; m_chk = 0; m_len = 0; m_tmo = 0;
            if (outq.size() != 0) begin
                if (out_ready) void'(outq.pop_front());
            end else if (in_frame) begin
                if (in_valid) begin
                    idle = 0;
                    frame.push_back(in_data);
                    if (frame.size() == 1) begin
                        if (in_data == 0 || int'(in_data) > MAXP) begin
                            m_len = 1;
                            in_frame = 0;
                        end
                    end else if (frame.size() == int'(frame[0]) + 2) begin
                        fsum = 0;
                        foreach (frame[i]) fsum += int'(frame[i]);
                        if (fsum % 256 == 0) begin
                            m_pkt = 1;
                            for (int i = 1; i < frame.size() - 1; i++) outq.push_back(frame[i]);
                        end else begin
                            m_chk = 1;
                        end
                        in_frame = 0;
                    end
                end else begin
                    idle++;
                    if (idle == TMO - 1) begin
                        m_tmo = 1;
                        in_frame = 0;
                    end
                end
            end else if (in_valid && in_data == SOF) begin
                in_frame = 1;
                frame.delete();
                idle = 0;
            end
            if ((m_chk || m_len || m_tmo) && m_cnt < 255) m_cnt++;
        end
    end

    // ---------------- per-cycle compare + beat capture ----------------
    logic [7:0] got[$];

    always @(negedge clk) begin
        check("in_ready", in_ready, outq.size() == 0);
        check("out_valid", out_valid, outq.size() != 0);
        if (outq.size() != 0) begin
            check("out_data", out_data, outq[0]);
            check("out_last", out_last, outq.size() == 1);
        end
        check("pkt_ok", pkt_ok, m_pkt);
        check("err_chk", err_chk, m_chk);
        check("err_len", err_len, m_len);
        check("err_timeout", err_timeout, m_tmo);
        check("err_count", err_count, m_cnt);
        if (out_valid && out_ready) got.push_back(out_data);
    end

    // ---------------- stimulus ----------------
    logic [7:0] seq[$];
    logic [7:0] exp_beats[$];

    // Present one byte and hold it until the DUT consumes it (bounded).
    task automatic send_byte(input logic [7:0] b);
        bit rdy;
        int n;
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #2;
            if (rdy) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_beats(string name);
        check({name, "_count"}, got.size(), exp_beats.size());
        foreach (exp_beats[i]) begin
            if (i < got.size()) check({name, "_beat"}, got[i], exp_beats[i]);
        end
        got.delete();
    endtask

    int k;

    initial begin
        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_err_count", err_count, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle_cycles(2);

        // good frame
        got.delete();
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_seq();
        idle_cycles(8);
        exp_beats = '{8'h11, 8'h22, 8'h33};
        check_beats("good");
        check("good_errcnt", err_count, 0);

        // bad checksum, then a good frame
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
        send_seq();
        idle_cycles(8);
        exp_beats.delete();
        check_beats("badchk");
        check("badchk_errcnt", err_count, 1);
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_seq();
        idle_cycles(8);
        exp_beats = '{8'h11, 8'h22, 8'h33};
        check_beats("after_bad");

        // length errors
        seq = '{8'hA5, 8'h00};
        send_seq();
        idle_cycles(3);
        check("len0_errcnt", err_count, 2);
        seq = '{8'hA5, 8'h11, 8'h01, 8'h02, 8'h03};
        send_seq();
        idle_cycles(3);
        check("len17_errcnt", err_count, 3);
        exp_beats.delete();
        check_beats("len17");

        // resync through garbage, SOF value inside payload
        seq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'hA5, 8'h01, 8'h58};
        send_seq();
        idle_cycles(8);
        exp_beats = '{8'hA5, 8'h01};
        check_beats("resync");
        check("resync_errcnt", err_count, 3);

        // inter-byte timeout
        seq = '{8'hA5, 8'h02, 8'h11};
        send_seq();
        k = 0;
        while (k < 70) begin
            @(negedge clk);
            if (err_timeout) break;
            k++;
        end
        check("timeout_cycle", k, 49);
        @(posedge clk);
        #2;
        idle_cycles(10);
        check("timeout_errcnt", err_count, 4);
        seq = '{8'hA5, 8'h01, 8'h7E, 8'h81};
        send_seq();
        idle_cycles(6);
        exp_beats = '{8'h7E};
        check_beats("after_tmo");

        // backpressure: out_ready toggles 1,0,1,0...
        seq = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
        send_seq();
        k = 0;
        while (got.size() < 4 && k < 40) begin
            out_ready = ~k[0];
            @(posedge clk);
            #2;
            k++;
        end
        out_ready = 1'b1;
        idle_cycles(3);
        exp_beats = '{8'h01, 8'h02, 8'h03, 8'h04};
        check_beats("bp");

        // reset in the middle of SEND
        out_ready = 1'b0;
        seq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
        send_seq();
        idle_cycles(2);
        check("pre_rst_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_err_count", err_count, 0);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        got.delete();
        @(posedge clk);
        #2;
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        send_seq();
        idle_cycles(8);
        exp_beats = '{8'h11, 8'h22, 8'h33};
        check_beats("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
